// File: rtl/uabc_acc_seq_pkg.sv
// Shared types and constants for the uabc_acc_seq accumulation sequencer.
// Build option: UABC_SAT_EN selects saturating accumulation.
package uabc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned UIO_START    = 0;
  localparam int unsigned UIO_VALID    = 1;
  localparam int unsigned UIO_BYTE_SEL = 2;
  localparam int unsigned UIO_ABORT    = 3;
  localparam int unsigned UIO_BUSY     = 4;
  localparam int unsigned UIO_DONE     = 5;
  localparam int unsigned UIO_OVF      = 6;
  localparam int unsigned UIO_READY    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // a zero count requests the maximum run of 16
  function automatic logic [4:0] cnt_load(
    input logic [3:0] n
  );
    return (n == 4'd0) ? 5'd16 : {1'b0, n};
  endfunction

endpackage

// File: rtl/uabc_acc_seq_if.sv
// TinyTapeout-style pin bundle for the accumulation sequencer.
// Build option: none.
interface uabc_acc_seq_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/uabc_acc_dp.sv
// Combinational datapath: operand adder with carry, wrap/saturate, byte mux.
// Build option: UABC_SAT_EN clamps the sum at the maximum on carry out.
module uabc_acc_dp
  import uabc_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [7:0]       opnd_i,
  input  logic             byte_sel_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o,
  output logic [7:0]       byte_o
);

  logic [ACC_W:0] raw;
  logic [15:0]    acc_ext;

  assign raw = {1'b0, acc_i}
             + {{(ACC_W-7){1'b0}}, opnd_i};

  assign carry_o = raw[ACC_W];

`ifdef UABC_SAT_EN
  assign sum_o = carry_o ? '1 : raw[ACC_W-1:0];
`else
  assign sum_o = raw[ACC_W-1:0];
`endif

  // widen so the high view is zero-padded for any ACC_W
  assign acc_ext = 16'(acc_i);

  assign byte_o = byte_sel_i ? acc_ext[15:8]
                             : acc_ext[7:0];

endmodule

// File: rtl/uabc_acc_seq.sv
// Multi-operand accumulation sequencer, TinyTapeout user top.
// Build option: UABC_SAT_EN (saturating accumulator, see uabc_acc_dp).
module uabc_acc_seq
  import uabc_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input logic          clk,
  input logic          rst_n,
  uabc_acc_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             start;
  logic             valid;
  logic             byte_sel;
  logic             abort;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [7:0]       out_byte;
  logic [7:0]       status;
  logic             unused_uio;

  assign start    = bus.uio_in[UIO_START];
  assign valid    = bus.uio_in[UIO_VALID];
  assign byte_sel = bus.uio_in[UIO_BYTE_SEL];
  assign abort    = bus.uio_in[UIO_ABORT];

  assign unused_uio = ^bus.uio_in[7:4];

  uabc_acc_dp #(
    .ACC_W(ACC_W)
  ) u_dp (
    .acc_i     (acc_q),
    .opnd_i    (bus.ui_in),
    .byte_sel_i(byte_sel),
    .sum_o     (sum),
    .carry_o   (carry),
    .byte_o    (out_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (bus.ena) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ready_d = ready_q;

    // abort wins over start and valid; result is kept
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = cnt_load(bus.ui_in[3:0]);
            done_d  = 1'b0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (valid) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // status flags are registered copies of the next state
    busy_d  = (state_d == ACCUM);
    ready_d = (state_d == ACCUM);
  end

  always_comb begin
    status            = '0;
    status[UIO_BUSY]  = busy_q;
    status[UIO_DONE]  = done_q;
    status[UIO_OVF]   = ovf_q;
    status[UIO_READY] = ready_q;
  end

  assign bus.uo_out  = out_byte;
  assign bus.uio_out = status;
  assign bus.uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_uabc_acc_seq.sv
// Self-checking bench for uabc_acc_seq: vector table, corner sequences, random run.
// Build option: UABC_SAT_EN changes the expected overflow values.
module tb_uabc_acc_seq;

  localparam int ACC_W = 10;
  localparam int MAXV  = 1 << ACC_W;

  localparam logic [7:0] ST = 8'h01;
  localparam logic [7:0] VA = 8'h02;
  localparam logic [7:0] BS = 8'h04;
  localparam logic [7:0] AB = 8'h08;

`ifdef UABC_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [7:0] OVF_LO = 8'hFF;
  localparam logic [7:0] OVF_HI = 8'h03;
`else
  localparam bit SAT = 1'b0;
  localparam logic [7:0] OVF_LO = 8'hFB;
  localparam logic [7:0] OVF_HI = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uabc_acc_seq_if bus();

  uabc_acc_seq #(
    .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_acc;
  int m_rem;
  bit m_ovf;
  bit m_done;

  typedef struct {
    bit         e;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] x_uo;
    logic [7:0] x_uio;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(bit e, logic [7:0] ui, logic [7:0] uio,
                              logic [7:0] xo, logic [7:0] xs);
    vec_t v;
    v.e = e; v.ui = ui; v.uio = uio; v.x_uo = xo; v.x_uio = xs;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_rem = 0; m_ovf = 0; m_done = 0;
  endtask

  // runs while operands remain; idle/finished otherwise
  task automatic model_step(bit e, logic [7:0] ui, logic [7:0] uio);
    int s;
    if (!e) return;
    if (uio[3]) begin
      m_rem = 0;
      m_done = 0;
    end else if (m_rem == 0) begin
      if (uio[0]) begin
        m_acc = 0; m_ovf = 0; m_done = 0;
        m_rem = (ui[3:0] == 0) ? 16 : int'(ui[3:0]);
      end
    end else if (uio[1]) begin
      s = m_acc + int'(ui);
      if (s >= MAXV) begin
        m_ovf = 1;
        s = SAT ? MAXV - 1 : s - MAXV;
      end
      m_acc = s;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1;
    end
  endtask

  function automatic logic [7:0] m_uo(bit bs);
    int v;
    v = bs ? (m_acc / 256) : (m_acc % 256);
    return 8'(v);
  endfunction

  function automatic logic [7:0] m_uio();
    logic [7:0] r;
    r = 8'h00;
    r[7] = (m_rem > 0);
    r[6] = m_ovf;
    r[5] = m_done;
    r[4] = (m_rem > 0);
    return r;
  endfunction

  task automatic tick(bit e, logic [7:0] ui, logic [7:0] uio, string nm);
    bus.ena = e; bus.ui_in = ui; bus.uio_in = uio;
    @(posedge clk);
    model_step(e, ui, uio);
    #1;
    chk({nm, "/uo"}, bus.uo_out, m_uo(uio[2]));
    chk({nm, "/uio"}, bus.uio_out, m_uio());
  endtask

  initial begin
    bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
    model_reset();

    tv[0]  = mk(1, 8'd3,   ST, 8'h00, 8'h90);
    tv[1]  = mk(1, 8'd10,  VA, 8'd10, 8'h90);
    tv[2]  = mk(1, 8'd20,  VA, 8'd30, 8'h90);
    tv[3]  = mk(1, 8'd30,  VA, 8'h3C, 8'h20);
    tv[4]  = mk(1, 8'd0,   8'h00, 8'h3C, 8'h20);
    tv[5]  = mk(1, 8'd2,   ST, 8'h00, 8'h90);
    tv[6]  = mk(1, 8'd200, VA, 8'hC8, 8'h90);
    tv[7]  = mk(1, 8'd0,   8'h00, 8'hC8, 8'h90);
    tv[8]  = mk(1, 8'd100, VA, 8'h2C, 8'h20);
    tv[9]  = mk(1, 8'd0,   BS, 8'h01, 8'h20);
    tv[10] = mk(1, 8'd5,   ST, 8'h00, 8'h90);
    tv[11] = mk(1, 8'd255, VA, 8'hFF, 8'h90);
    tv[12] = mk(1, 8'd255, VA, 8'hFE, 8'h90);
    tv[13] = mk(1, 8'd255, VA, 8'hFD, 8'h90);
    tv[14] = mk(1, 8'd255, VA, 8'hFC, 8'h90);
    tv[15] = mk(1, 8'd255, VA, OVF_LO, 8'h60);
    tv[16] = mk(1, 8'd0,   BS, OVF_HI, 8'h60);

    #12;
    chk("rst_uo", bus.uo_out, 8'h00);
    chk("rst_uio", bus.uio_out, 8'h00);
    chk("rst_oe", bus.uio_oe, 8'hF0);
    rst_n = 1'b1;

    repeat (3) tick(1, 8'h00, 8'h00, "idle");
    chk("idle_uo", bus.uo_out, 8'h00);

    for (int i = 0; i < 17; i++) begin
      tick(tv[i].e, tv[i].ui, tv[i].uio, $sformatf("vec%0d", i));
      chk($sformatf("tv%0d_uo", i), bus.uo_out, tv[i].x_uo);
      chk($sformatf("tv%0d_uio", i), bus.uio_out, tv[i].x_uio);
    end

    tick(1, 8'd4, ST, "ab_start");
    tick(1, 8'd7, VA, "ab_op7");
    tick(1, 8'd9, VA, "ab_op9");
    tick(1, 8'd9, VA | AB, "ab_abort");
    chk("abort_uo", bus.uo_out, 8'h10);
    chk("abort_uio", bus.uio_out, 8'h00);
    tick(1, 8'd1, ST, "rs_start");
    tick(1, 8'd5, VA, "rs_op5");
    chk("restart_uo", bus.uo_out, 8'h05);
    chk("restart_uio", bus.uio_out, 8'h20);

    tick(1, 8'd3, ST, "fz_start");
    tick(1, 8'd1, VA, "fz_op1");
    for (int i = 0; i < 4; i++) begin
      tick(0, 8'd50, VA | ST, "fz_hold");
      chk("freeze_uo", bus.uo_out, 8'h01);
      chk("freeze_uio", bus.uio_out, 8'h90);
    end
    tick(1, 8'd2, VA, "fz_op2");
    tick(1, 8'd3, VA, "fz_op3");
    chk("thaw_uo", bus.uo_out, 8'h06);
    chk("thaw_uio", bus.uio_out, 8'h20);

    tick(1, 8'hF0, ST, "n0_start");
    for (int i = 0; i < 16; i++) begin
      tick(1, 8'd1, VA, "n0_op");
      if (i == 14) chk("n0_busy15", bus.uio_out, 8'h90);
    end
    chk("n0_uo", bus.uo_out, 8'h10);
    chk("n0_uio", bus.uio_out, 8'h20);

    tick(1, 8'd5, ST, "ar_start");
    tick(1, 8'd200, VA, "ar_op");
    tick(1, 8'd200, VA, "ar_op");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_uo", bus.uo_out, 8'h00);
    chk("arst_uio", bus.uio_out, 8'h00);
    chk("arst_oe", bus.uio_oe, 8'hF0);
    #1 bus.uio_in = BS;
    #1;
    chk("arst_hi", bus.uo_out, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      logic [7:0] u;
      bit e;
      e = ($urandom_range(0, 9) != 0);
      u = 8'($urandom) & 8'hF0;
      u[0] = ($urandom_range(0, 3) == 0);
      u[1] = ($urandom_range(0, 9) < 6);
      u[2] = $urandom_range(0, 1) == 1;
      u[3] = ($urandom_range(0, 19) == 0);
      tick(e, 8'($urandom), u, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uabc_acc_seq.md
# uabc_acc_seq

Multi-operand accumulation sequencer wrapped as a TinyTapeout user top. It takes over the design's 8-bit operand adder and drives it for a host-selected run of 1–16 operands. Operands arrive one per handshake on `ui_in`. The result stays on `uo_out` along with busy, done, ready and overflow status, and remains there until the next run.

## Interface
Parameters:
- `ACC_W`, default 10: accumulator width, legal range 9..16. The high byte view is `acc[ACC_W-1:8]`, zero-padded to 8 bits.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: when 0, all registers hold their values.
- `ui_in` in 8: in IDLE/DONE, bits [3:0] are the operand count N (0 means 16); in ACCUM, the full 8 bits are the operand.
- `uio_in` in 8: bit 0 start, bit 1 valid, bit 2 byte_sel, bit 3 abort; bits [7:4] are ignored.
- `uo_out` out 8: `acc[7:0]` when byte_sel=0; the zero-padded high byte when byte_sel=1.
- `uio_out` out 8: bit 4 busy, bit 5 done, bit 6 ovf, bit 7 ready; bits [3:0] are always 0.
- `uio_oe` out 8: constant 8'hF0.

## Operation
- All inputs are synchronous to `clk`.
- FSM states are IDLE, ACCUM and DONE. Reset state is IDLE.
- IDLE or DONE, start=1:
  - acc←0, ovf←0, cnt←(N==0 ? 16 : N), done←0, go to ACCUM.
  - In DONE, this restarts directly.
- ACCUM:
  - ready=1 and busy=1.
  - On each edge with valid=1: acc←acc+ui_in (8-bit operand zero-extended), cnt←cnt−1.
  - On the edge that accepts the operand with cnt==1: go to DONE, done←1.
  - valid=0 cycles are gaps; they do not change state or counters.
  - start is ignored in ACCUM.
- DONE: done=1; acc and ovf hold until the next start or abort.
- Abort, any state:
  - Takes priority over start and valid in the same cycle.
  - Goes to IDLE and clears done; acc and ovf keep their values.
- Arithmetic: the sum is computed at ACC_W+1 bits, and the carry out of bit ACC_W−1 sets sticky ovf.
  - Default build wraps (acc takes the low ACC_W bits).
  - The saturating build is described under Configuration.
- `ena`=0 freezes the FSM, acc, cnt and flags. Outputs keep reflecting the frozen state.
- byte_sel is a pure combinational output mux with no state effect.

## Timing
- Reset values:
  - state IDLE, acc 0, cnt 0, ovf 0, done 0.
  - `uo_out`=0, `uio_out`=0, `uio_oe`=8'hF0.
- Start seen at edge k: busy=1 and ready=1 after edge k.
- Operand accepted at edge k: the updated acc is on `uo_out` after edge k, so latency is 1 cycle.
- Last operand accepted at edge k: done=1, busy=0 and ready=0 after edge k.
- Throughput: one operand per cycle when valid is held high.
- Asynchronous reset mid-run: every register returns to its reset value immediately, with no partial result retained.
- Status outputs (busy, done, ovf, ready) come straight from registers and are glitch-free.

## Configuration
- `UABC_SAT_EN` defined:
  - On carry out, acc clamps to 2^ACC_W−1 and ovf←1.
  - Further additions keep acc at the maximum.
- Not defined: acc wraps modulo 2^ACC_W and ovf←1 on carry out.
- ovf behaves identically in both builds; only the acc value differs.

## Structure
- Package `uabc_pkg` holds:
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - `uio` bit index constants (START, VALID, BYTE_SEL, ABORT, BUSY, DONE, OVF, READY);
  - the `UIO_OE_MASK`=8'hF0 constant.
- Sub-module `uabc_acc_dp` is combinational: adder with carry, saturation/wrap select under `UABC_SAT_EN`, and the byte_sel output mux.
- The FSM, cnt, acc and flags stay in the top.

## Test plan
- Reset: hold rst_n=0 → `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xF0. Release, then 3 idle cycles → still 0.
- Basic run: ui_in=3 with start; operands 10, 20, 30 with valid → done=1 one cycle after 30, `uo_out`=0x3C, ovf=0, busy=0.
- High byte: N=2, operands 200 and 100, valid gap between them → low byte 0x2C; byte_sel=1 → 0x01; ovf=0.
- Overflow (ACC_W=10): N=5, operand 255 five times.
  - Wrap build → low 0xFB, high 0x00, ovf=1.
  - `UABC_SAT_EN` build → low 0xFF, high 0x03, ovf=1.
- Abort and restart:
  - N=4, operands 7 and 9, then abort with valid=1 in the same cycle → IDLE; acc=16 (9 not double-counted); done=0, busy=0.
  - Then start with N=1 and operand 5 → `uo_out`=0x05.
- ena freeze and count 0:
  - ena=0 for 4 cycles mid-run with valid=1 → acc and cnt unchanged.
  - N=0 → exactly 16 operands of 1 accepted, then `uo_out`=0x10 and done=1.
